// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and types for the FIFO read-side blocks.
//   FIFO_DSIZE / FIFO_PACK : default word width and words per packed beat
//   CNT_W                  : accumulator count width for the default PACK
//   oreg_state_e           : output register occupancy
//   beat_t                 : packed beat {data, keep, last} at default sizes
//   beat_width()           : flattened beat width for arbitrary sizes
package fifo_pkg;

  localparam int unsigned FIFO_DSIZE = 32;
  localparam int unsigned FIFO_PACK  = 2;
  localparam int unsigned CNT_W      = $clog2(FIFO_PACK);

  typedef enum logic {
    OREG_EMPTY = 1'b0,
    OREG_FULL  = 1'b1
  } oreg_state_e;

  typedef struct packed {
    logic [FIFO_DSIZE*FIFO_PACK-1:0] data;
    logic [FIFO_PACK-1:0]            keep;
    logic                            last;
  } beat_t;

  // Same field order as beat_t: data in the MSBs, last in bit 0.
  function automatic int unsigned beat_width(input int unsigned dsize,
                                             input int unsigned pack);
    return dsize * pack + pack + 1;
  endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// fifo_rd_packer_if: bundles the FIFO read port and the packed output stream.
//   rdata/rempty/rinc          : FIFO first-word-fall-through read port
//   flush                      : request to emit the pending partial beat
//   m_valid/m_ready            : output stream handshake
//   m_data/m_keep/m_last       : output beat payload
// Modport slave is the packer's view, master is the surrounding environment.
interface fifo_rd_packer_if
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE = FIFO_DSIZE,
  parameter int unsigned PACK  = FIFO_PACK
);

  logic [DSIZE-1:0]      rdata;
  logic                  rempty;
  logic                  rinc;
  logic                  flush;
  logic                  m_valid;
  logic                  m_ready;
  logic [DSIZE*PACK-1:0] m_data;
  logic [PACK-1:0]       m_keep;
  logic                  m_last;

  modport slave (
    input  rdata, rempty, flush, m_ready,
    output rinc, m_valid, m_data, m_keep, m_last
  );

  modport master (
    output rdata, rempty, flush, m_ready,
    input  rinc, m_valid, m_data, m_keep, m_last
  );

endinterface

// File: rtl/fifo_beat_reg.sv
// fifo_beat_reg: single-entry output register with valid/ready hold.
//   clk, rst  : clock, asynchronous active-high reset
//   i_load    : load i_data this cycle (only asserted when o_free is high)
//   i_data    : beat to load
//   i_ready   : downstream accept
//   o_valid   : beat held
//   o_data    : held beat, stable while o_valid until accepted
//   o_free    : register can take a new beat this cycle (empty or draining)
module fifo_beat_reg
  import fifo_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_free
);

  oreg_state_e  r_state;
  logic [W-1:0] r_data;

  assign o_valid = (r_state == OREG_FULL);
  assign o_data  = r_data;
  // A transfer in the same cycle frees the slot, so drain and reload never bubble.
  assign o_free  = (r_state == OREG_EMPTY) || i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= OREG_EMPTY;
      r_data  <= '0;
    end else if (i_load) begin
      r_state <= OREG_FULL;
      r_data  <= i_data;
    end else if (r_state == OREG_FULL && i_ready) begin
      r_state <= OREG_EMPTY;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains a FWFT FIFO read port and packs PACK words per beat.
//   rclk, rrst : read-domain clock, asynchronous active-high reset
//   bus.rdata/rempty/rinc    : FIFO head word, empty flag, pop (combinational)
//   bus.flush                : emit whatever words are pending as a partial beat
//   bus.m_valid/m_ready      : output handshake
//   bus.m_data/m_keep/m_last : beat, word 0 in the LSBs; keep per word;
//                              last marks a beat closed by a flush
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE = FIFO_DSIZE,
  parameter int unsigned PACK  = FIFO_PACK
) (
  input  logic            rclk,
  input  logic            rrst,
  fifo_rd_packer_if.slave bus
);

  localparam int unsigned   CW        = $clog2(PACK);
  localparam int unsigned   BW        = beat_width(DSIZE, PACK);
  localparam int unsigned   SW        = DSIZE * (PACK - 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(PACK - 1);

  logic [SW-1:0]         r_slots;
  logic [SW-1:0]         w_slots_nxt;
  logic [CW-1:0]         r_acc_cnt;
  logic [CW-1:0]         w_acc_nxt;
  logic [CW-1:0]         w_cnt_eff;
  logic                  r_flush_pend;
  logic                  w_pend_nxt;

  logic                  w_oreg_free;
  logic                  w_oreg_valid;
  logic [BW-1:0]         w_oreg_beat;
  logic                  w_pop;
  logic                  w_flush_req;
  logic                  w_load;
  logic [DSIZE*PACK-1:0] w_ld_data;
  logic [PACK-1:0]       w_ld_keep;
  logic                  w_ld_last;
  logic [BW-1:0]         w_ld_beat;

  assign w_flush_req = bus.flush | r_flush_pend;

  // Slots below the last one always have room; the last word needs the OREG.
  // A pending flush freezes popping so the partial beat keeps its contents.
  assign w_pop = ~bus.rempty & ~rrst & ~r_flush_pend &
                 ((r_acc_cnt != LAST_SLOT) | w_oreg_free);
  assign bus.rinc = w_pop;

  always_comb begin
    w_slots_nxt = r_slots;
    w_acc_nxt   = r_acc_cnt;
    w_pend_nxt  = r_flush_pend;
    w_cnt_eff   = r_acc_cnt;
    w_load      = 1'b0;
    w_ld_data   = '0;
    w_ld_keep   = '0;
    w_ld_last   = 1'b0;

    if (w_pop && r_acc_cnt == LAST_SLOT) begin
      // Popped word completes the beat; a coincident flush only tags it last.
      w_load      = 1'b1;
      w_ld_data   = {bus.rdata, r_slots};
      w_ld_keep   = '1;
      w_ld_last   = w_flush_req;
      w_acc_nxt   = '0;
      w_pend_nxt  = 1'b0;
    end else begin
      if (w_pop) begin
        for (int unsigned i = 0; i < PACK - 1; i++) begin
          if (CW'(i) == r_acc_cnt) begin
            w_slots_nxt[i*DSIZE +: DSIZE] = bus.rdata;
          end
        end
        w_cnt_eff = r_acc_cnt + CW'(1);
      end
      w_acc_nxt = w_cnt_eff;

      if (w_flush_req) begin
        if (w_cnt_eff == '0) begin
          w_pend_nxt = 1'b0;
        end else if (w_oreg_free) begin
          // Partial beat includes a word popped this very cycle.
          w_load     = 1'b1;
          w_ld_last  = 1'b1;
          w_acc_nxt  = '0;
          w_pend_nxt = 1'b0;
          for (int unsigned i = 0; i < PACK - 1; i++) begin
            if (CW'(i) < w_cnt_eff) begin
              w_ld_data[i*DSIZE +: DSIZE] = w_slots_nxt[i*DSIZE +: DSIZE];
              w_ld_keep[i]                = 1'b1;
            end
          end
        end else begin
          w_pend_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_slots      <= '0;
      r_acc_cnt    <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_slots      <= w_slots_nxt;
      r_acc_cnt    <= w_acc_nxt;
      r_flush_pend <= w_pend_nxt;
    end
  end

  assign w_ld_beat = {w_ld_data, w_ld_keep, w_ld_last};

  fifo_beat_reg #(
    .W (BW)
  ) u_oreg (
    .clk     (rclk),
    .rst     (rrst),
    .i_load  (w_load),
    .i_data  (w_ld_beat),
    .i_ready (bus.m_ready),
    .o_valid (w_oreg_valid),
    .o_data  (w_oreg_beat),
    .o_free  (w_oreg_free)
  );

  assign bus.m_valid = w_oreg_valid;
  assign bus.m_data  = w_oreg_beat[BW-1 -: DSIZE*PACK];
  assign bus.m_keep  = w_oreg_beat[PACK:1];
  assign bus.m_last  = w_oreg_beat[0];

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed vectors for fifo_rd_packer at DSIZE=32, PACK=2.
//   A queue models the FIFO; each vector is one clock with the expected rinc
//   (just before the edge) and the expected output beat (just after it).
module tb_fifo_rd_packer;
  import fifo_pkg::*;

  logic rclk = 1'b0;
  logic rrst;
  always #5 rclk = ~rclk;

  fifo_rd_packer_if #(.DSIZE(32), .PACK(2)) bus ();

  fifo_rd_packer #(
    .DSIZE (32),
    .PACK  (2)
  ) dut (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (bus)
  );

  typedef struct {
    logic        rst;
    logic        push;
    logic [31:0] wd;
    logic        rdy;
    logic        fl;
    logic        e_rinc;
    logic        e_v;
    beat_t       e;
  } vec_t;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [31:0] q[$];
  logic        pop_now;
  vec_t        vt[17];

  function automatic vec_t mk(input logic rst, input logic push, input logic [31:0] wd,
                              input logic rdy, input logic fl, input logic er,
                              input logic ev, input logic [63:0] ed,
                              input logic [1:0] ek, input logic el);
    vec_t v;
    v.rst = rst; v.push = push; v.wd = wd; v.rdy = rdy; v.fl = fl;
    v.e_rinc = er; v.e_v = ev;
    v.e.data = ed; v.e.keep = ek; v.e.last = el;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    bus.rempty = (q.size() == 0);
    bus.rdata  = (q.size() != 0) ? q[0] : 32'h0;
  endtask

  task automatic do_reset();
    rrst      = 1'b1;
    bus.flush = 1'b0;
    q.delete();
    refresh();
    @(posedge rclk);
    @(negedge rclk);
    rrst = 1'b0;
    @(posedge rclk);
    #1;
  endtask

  // Entered and left at posedge+1.
  task automatic cyc(input string tag, input logic e_rinc);
    @(negedge rclk);
    pop_now = bus.rinc;
    chk({tag, ".rinc"}, 64'(bus.rinc), 64'(e_rinc));
    @(posedge rclk);
    #1;
    if (pop_now && q.size() != 0) void'(q.pop_front());
    bus.flush = 1'b0;
    refresh();
  endtask

  task automatic apply(input string tag, input vec_t v);
    if (v.rst) do_reset();
    if (v.push) begin
      q.push_back(v.wd);
      refresh();
    end
    bus.m_ready = v.rdy;
    bus.flush   = v.fl;
    cyc(tag, v.e_rinc);
    chk({tag, ".valid"}, 64'(bus.m_valid), 64'(v.e_v));
    if (v.e_v) begin
      chk({tag, ".data"}, bus.m_data, v.e.data);
      chk({tag, ".keep"}, 64'(bus.m_keep), 64'(v.e.keep));
      chk({tag, ".last"}, 64'(bus.m_last), 64'(v.e.last));
    end
  endtask

  initial begin
    //            rst   push  word   rdy   fl    rinc  valid data                    keep   last
    // stream
    vt[0]  = mk(1'b1, 1'b1, 32'h11, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0,                  2'b00, 1'b0);
    vt[1]  = mk(1'b0, 1'b1, 32'h22, 1'b1, 1'b0, 1'b1, 1'b1, 64'h00000022_00000011, 2'b11, 1'b0);
    vt[2]  = mk(1'b0, 1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0,                  2'b00, 1'b0);
    vt[3]  = mk(1'b0, 1'b1, 32'h44, 1'b1, 1'b0, 1'b1, 1'b1, 64'h00000044_00000033, 2'b11, 1'b0);
    vt[4]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 64'h0,                  2'b00, 1'b0);
    // back-pressure
    vt[5]  = mk(1'b1, 1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,                  2'b00, 1'b0);
    vt[6]  = mk(1'b0, 1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b1, 64'h00000022_00000011, 2'b11, 1'b0);
    vt[7]  = mk(1'b0, 1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 1'b1, 64'h00000022_00000011, 2'b11, 1'b0);
    vt[8]  = mk(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1, 64'h00000022_00000011, 2'b11, 1'b0);
    vt[9]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 64'h00000022_00000011, 2'b11, 1'b0);
    vt[10] = mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 64'h00000044_00000033, 2'b11, 1'b0);
    vt[11] = mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 64'h0,                  2'b00, 1'b0);
    // flush partial, then the accumulator restarts at slot 0
    vt[12] = mk(1'b1, 1'b1, 32'hAA, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0,                  2'b00, 1'b0);
    vt[13] = mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 64'h00000000_000000AA, 2'b01, 1'b1);
    vt[14] = mk(1'b0, 1'b1, 32'h01, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0,                  2'b00, 1'b0);
    vt[15] = mk(1'b0, 1'b1, 32'h02, 1'b1, 1'b0, 1'b1, 1'b1, 64'h00000002_00000001, 2'b11, 1'b0);
    vt[16] = mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 64'h0,                  2'b00, 1'b0);

    // Reset state, with a word waiting so a pop during reset would show.
    rrst        = 1'b1;
    bus.m_ready = 1'b0;
    bus.flush   = 1'b0;
    q.push_back(32'h99);
    refresh();
    #12;
    chk("rst.rinc",  64'(bus.rinc),    64'h0);
    chk("rst.valid", 64'(bus.m_valid), 64'h0);
    chk("rst.data",  bus.m_data,       64'h0);
    chk("rst.keep",  64'(bus.m_keep),  64'h0);
    chk("rst.last",  64'(bus.m_last),  64'h0);

    for (int i = 0; i < 17; i++) apply($sformatf("v%0d", i), vt[i]);

    // Flush blocked by a full OREG, executes when it frees.
    apply("fb0", mk(1'b1, 1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,                  2'b00, 1'b0));
    apply("fb1", mk(1'b0, 1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b1, 64'h00000022_00000011, 2'b11, 1'b0));
    apply("fb2", mk(1'b0, 1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 1'b1, 64'h00000022_00000011, 2'b11, 1'b0));
    apply("fb3", mk(1'b0, 1'b1, 32'h44, 1'b0, 1'b1, 1'b0, 1'b1, 64'h00000022_00000011, 2'b11, 1'b0));
    apply("fb4", mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 64'h00000000_00000033, 2'b01, 1'b1));
    apply("fb5", mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 64'h0,                  2'b00, 1'b0));
    apply("fb6", mk(1'b0, 1'b1, 32'h55, 1'b1, 1'b0, 1'b1, 1'b1, 64'h00000055_00000044, 2'b11, 1'b0));
    apply("fb7", mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 64'h0,                  2'b00, 1'b0));

    // Flush in the same cycle as the beat-completing pop: one full beat, last=1.
    apply("fc0", mk(1'b1, 1'b1, 32'h01, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0,                  2'b00, 1'b0));
    apply("fc1", mk(1'b0, 1'b1, 32'h02, 1'b1, 1'b1, 1'b1, 1'b1, 64'h00000002_00000001, 2'b11, 1'b1));
    apply("fc2", mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 64'h0,                  2'b00, 1'b0));
    apply("fc3", mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 64'h0,                  2'b00, 1'b0));

    // Reset mid-beat: asynchronous clear, slot contents discarded.
    apply("rm0", mk(1'b1, 1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,                  2'b00, 1'b0));
    apply("rm1", mk(1'b0, 1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b1, 64'h00000022_00000011, 2'b11, 1'b0));
    apply("rm2", mk(1'b0, 1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 1'b1, 64'h00000022_00000011, 2'b11, 1'b0));
    q.push_back(32'h44);
    refresh();
    #2;
    rrst = 1'b1;
    #1;
    chk("rm.valid", 64'(bus.m_valid), 64'h0);
    chk("rm.data",  bus.m_data,       64'h0);
    chk("rm.keep",  64'(bus.m_keep),  64'h0);
    chk("rm.last",  64'(bus.m_last),  64'h0);
    chk("rm.rinc",  64'(bus.rinc),    64'h0);
    @(posedge rclk);
    #1;
    rrst = 1'b0;
    apply("rm3", mk(1'b0, 1'b1, 32'h55, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0,                  2'b00, 1'b0));
    apply("rm4", mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 64'h00000055_00000044, 2'b11, 1'b0));
    apply("rm5", mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 64'h0,                  2'b00, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side drain stage placed directly after the asynchronous FIFO, in the read clock domain. It pops DSIZE-bit words from the FIFO's first-word-fall-through read port (rdata valid whenever rempty is low, rinc pops). It packs PACK consecutive words into one wide beat and presents the beat on a valid/ready stream. A flush request emits a partial beat with per-word keep bits, so trailing words never stall in the packer.

## Interface
- DSIZE, 32: FIFO word width in bits.
- PACK, 2: words per output beat; legal range 2–8.
- rclk  in  1  read-domain clock; all state updates on rising edge.
- rrst  in  1  reset, asynchronous assert, active-high; synchronous deassert is provided externally.
- rdata  in  DSIZE  FIFO head word; valid while rempty=0.
- rempty  in  1  FIFO empty flag.
- rinc  out  1  FIFO pop; combinational.
- flush  in  1  single-cycle request to emit the pending partial beat.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- m_data  out  DSIZE*PACK  packed beat; word 0 (first popped) in bits [DSIZE-1:0].
- m_keep  out  PACK  bit i set = word i valid.
- m_last  out  1  beat was closed by a flush.

## Operation
- Accumulator: PACK-1 word slots plus acc_cnt (0..PACK-1). Output register (OREG): data, keep, last and m_valid.
- OREG states:
  - EMPTY: m_valid=0.
  - FULL: m_valid=1.
  - Transfer occurs when m_valid && m_ready.
  - "oreg_free" = EMPTY, or FULL with a transfer this cycle.
- rinc = !rempty && !rrst && (acc_cnt < PACK-1 || oreg_free).
- Pop with acc_cnt < PACK-1 and no flush: the word is written to slot acc_cnt, and acc_cnt increments.
- Pop with acc_cnt = PACK-1: the word completes the beat. OREG loads {rdata, slots}, keep all ones, last = flush_req. acc_cnt goes to 0.
- flush_req = flush || flush_pend.
- Flush handling, when the popped word has not already closed a beat:
  - With acc_cnt + pop > 0 and oreg_free: OREG loads the valid words (including any word popped this cycle). Unused lanes are zero, keep marks the valid words, last=1. acc_cnt goes to 0 and flush_pend clears.
  - With words pending but OREG not free: flush_pend is set and held. While flush_pend=1, rinc=0. The flush executes on the first cycle OREG becomes free.
  - With acc_cnt=0 and no pop: no-op. flush_pend clears and no beat is emitted.
- Once m_valid is 1, m_data, m_keep and m_last are stable until the transfer. m_valid never drops without a transfer.
- Reset values: m_valid=0, m_data=0, m_keep=0, m_last=0, acc_cnt=0, flush_pend=0. Reset mid-beat discards accumulated words and the OREG beat; the FIFO is not popped during reset.

## Timing
- Pop-to-beat latency: the beat is visible the cycle after the rclk edge that pops its last word.
- Sustained throughput: one word per cycle with m_ready held high, i.e. one beat every PACK cycles.
- Back-pressure: with m_ready=0, the stage absorbs at most PACK-1 further words and then holds rinc=0.
- The same-cycle transfer and OREG load is bubble-free.
- Flush to partial beat: one cycle if OREG is free, otherwise one cycle after OREG frees.
- A flush arriving while flush_pend=1 is merged into the pending flush, not queued.

## Structure
- Shared package fifo_pkg:
  - Default DSIZE and PACK constants.
  - CNT_W = $clog2(PACK).
  - A typedef for the beat struct {data, keep, last}.
- Sub-module fifo_beat_reg: OREG with valid/ready hold logic, parameterized by beat width. Used once here and reusable at other FIFO outputs.
- Accumulator, acc_cnt, flush_pend and rinc logic stay in the top module.

## Test plan
- Stream: PACK=2, FIFO preloaded with 0x11,0x22,0x33,0x44, m_ready=1 → beats 0x00000022_00000011 then 0x00000044_00000033, keep=2'b11, last=0, rinc high 4 consecutive cycles.
- Back-pressure: same data, m_ready=0 → first beat held stable, one more word (0x33) absorbed, rinc=0 afterwards. Raising m_ready produces both beats in order with no bubble.
- Flush partial: one word 0xAA then flush → beat 0x00000000_000000AA, keep=2'b01, last=1, acc_cnt=0.
- Flush blocked: OREG full with m_ready=0, one word pending, flush pulse → flush_pend=1, rinc=0. On m_ready=1 the held beat transfers, then a partial beat keep=2'b01, last=1 follows.
- Flush with pop completing a beat: acc_cnt=1 holds 0x01, word 0x02 popped in the same cycle as flush → beat 0x00000002_00000001, keep=2'b11, last=1, no extra empty beat.
- Reset mid-beat: one word accumulated and OREG full, rrst asserted → all outputs zero immediately (asynchronous). After release, the next two popped words form a fresh beat.
